// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 slave, MSB first, one DATA_WIDTH-bit word per SSn-low frame.
// SCLK/SSn/MOSI pins are oversampled in the iClk domain through 2-flop synchronisers.
// Build macro SPI_SLAVE_ECHO_EN: each frame returns the previous good received word
// instead of iTx_Data (port list unchanged).
`timescale 1ns/1ps
module spi_slave #(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iSCLK,
  input  logic                  iSSn,
  input  logic                  iMOSI,
  output logic                  oMISO,
  output logic                  oMISO_OE,
  input  logic [DATA_WIDTH-1:0] iTx_Data,
  output logic [DATA_WIDTH-1:0] oRx_Data,
  output logic                  oRx_Valid,
  output logic                  oFrame_Err,
  output logic                  oBusy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, stateNext;

  logic sclkS1, sclkS2, sclkS2d;
  logic ssnS1, ssnS2, ssnS2d;
  logic mosiS1, mosiS2;
  logic syncV1, syncV2, ssnArmed;
  logic sclkRise, sclkFall, ssnRise, ssnFall;
  logic [DATA_WIDTH-1:0] txSr, rxSr, rxWord, txLoad;
  logic [CW-1:0] bitCnt;

`ifdef SPI_SLAVE_ECHO_EN
  logic unusedTx;
  assign unusedTx = ^iTx_Data;
  assign txLoad   = oRx_Data;
`else
  assign txLoad   = iTx_Data;
`endif

  // Pin synchronisers, delayed copies for edge detection, and SSn arming after reset.
  // The synchronisers reset to SSn=1, so a frame still active on the pins would look
  // like a fresh SSn fall; ssnArmed only sets once a genuine pin-derived high is seen.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      sclkS1   <= 1'b0;
      sclkS2   <= 1'b0;
      sclkS2d  <= 1'b0;
      ssnS1    <= 1'b1;
      ssnS2    <= 1'b1;
      ssnS2d   <= 1'b1;
      mosiS1   <= 1'b0;
      mosiS2   <= 1'b0;
      syncV1   <= 1'b0;
      syncV2   <= 1'b0;
      ssnArmed <= 1'b0;
    end else begin
      sclkS1  <= iSCLK;
      sclkS2  <= sclkS1;
      sclkS2d <= sclkS2;
      ssnS1   <= iSSn;
      ssnS2   <= ssnS1;
      ssnS2d  <= ssnS2;
      mosiS1  <= iMOSI;
      mosiS2  <= mosiS1;
      syncV1  <= 1'b1;
      syncV2  <= syncV1;
      if (syncV2 && ssnS2) ssnArmed <= 1'b1;
    end
  end

  assign sclkRise = sclkS2 & ~sclkS2d;
  assign sclkFall = ~sclkS2 & sclkS2d;
  assign ssnRise  = ssnS2 & ~ssnS2d;
  assign ssnFall  = ~ssnS2 & ssnS2d & ssnArmed;
  assign rxWord   = {rxSr[DATA_WIDTH-2:0], mosiS2};

  // State register
  always_ff @(posedge iClk) begin
    if (iRst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state logic; an SSn rise takes priority over a coincident SCLK rise
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:  if (ssnFall) stateNext = SHIFT;
      SHIFT: begin
        if (ssnRise) stateNext = IDLE;
        else if (sclkRise && bitCnt == LAST_BIT) stateNext = DONE;
      end
      DONE:  if (ssnRise) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Shift registers, bit counter, received word and status pulses
  always_ff @(posedge iClk) begin
    if (iRst) begin
      txSr       <= '0;
      rxSr       <= '0;
      bitCnt     <= '0;
      oRx_Data   <= '0;
      oRx_Valid  <= 1'b0;
      oFrame_Err <= 1'b0;
    end else begin
      oRx_Valid  <= 1'b0;
      oFrame_Err <= 1'b0;
      case (state)
        IDLE: begin
          if (ssnFall) begin
            txSr   <= txLoad;
            bitCnt <= '0;
          end
        end
        SHIFT: begin
          if (ssnRise) begin
            oFrame_Err <= 1'b1;
          end else if (sclkRise) begin
            rxSr <= rxWord;
            if (bitCnt == LAST_BIT) begin
              oRx_Data  <= rxWord;
              oRx_Valid <= 1'b1;
              bitCnt    <= FULL_CNT;
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end else if (sclkFall) begin
            txSr <= txSr << 1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pin-facing outputs; MISO is the head of the transmit register while shifting
  always_comb begin
    oMISO    = (state == SHIFT) ? txSr[DATA_WIDTH-1] : 1'b0;
    oMISO_OE = (state != IDLE);
    oBusy    = (state != IDLE);
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized self-checking bench for spi_slave acting as an SPI mode-0 master.
`timescale 1ns/1ps
module tb_spi_slave;
  localparam int W = 10;

  logic         iClk = 1'b0;
  logic         iRst, iSCLK, iSSn, iMOSI;
  logic         oMISO, oMISO_OE, oRx_Valid, oFrame_Err, oBusy;
  logic [W-1:0] iTx_Data, oRx_Data;

  always #5 iClk = ~iClk;

  spi_slave #(.DATA_WIDTH(W)) dut (
    .iClk(iClk), .iRst(iRst), .iSCLK(iSCLK), .iSSn(iSSn), .iMOSI(iMOSI),
    .oMISO(oMISO), .oMISO_OE(oMISO_OE), .iTx_Data(iTx_Data), .oRx_Data(oRx_Data),
    .oRx_Valid(oRx_Valid), .oFrame_Err(oFrame_Err), .oBusy(oBusy)
  );

  int vectors = 0;
  int miscompares = 0;
  int validSeen = 0;
  int errSeen = 0;
  logic [W-1:0] modelRx = '0;

  // Pulse counters sampled away from the active edge
  always @(negedge iClk) begin
    if (oRx_Valid === 1'b1) validSeen++;
    if (oFrame_Err === 1'b1) errSeen++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

  // Word the master should read back this frame
  function automatic logic [W-1:0] expTxWord(input logic [W-1:0] tx);
`ifdef SPI_SLAVE_ECHO_EN
    return modelRx;
`else
    return tx;
`endif
  endfunction

  // MISO stream seen by master over n rises: word MSB first, zeros past W bits
  function automatic logic [15:0] expMiso(input logic [W-1:0] word, input int unsigned n);
    logic [15:0] full;
    logic [15:0] mask;
    full = {word, 6'b0};
    mask = (n >= 16) ? 16'hFFFF : ~(16'hFFFF >> n);
    return full & mask;
  endfunction

  task automatic halfBit();
    repeat (6) @(negedge iClk);
  endtask

  // Master frame: n SCLK rises, MOSI from mosi[15] downward, MISO captured at each rise
  task automatic spiXfer(input logic [15:0] mosi, input int unsigned n, input logic [W-1:0] tx,
                         output logic [15:0] miso, output logic activeMid);
    miso = '0;
    activeMid = 1'b0;
    iTx_Data = tx;
    halfBit();
    iSSn = 1'b0;
    halfBit();
    for (int unsigned i = 0; i < n; i++) begin
      iMOSI = mosi[15-i];
      halfBit();
      iSCLK = 1'b1;
      miso[15-i] = oMISO;
      if (i == 0) begin
        activeMid = oMISO_OE & oBusy;
        iTx_Data = W'($urandom);
      end
      halfBit();
      iSCLK = 1'b0;
    end
    iMOSI = 1'b0;
    halfBit();
    iSSn = 1'b1;
    repeat (8) halfBit();
  endtask

  task automatic test_reset();
    iRst = 1'b1; iSCLK = 1'b0; iSSn = 1'b1; iMOSI = 1'b0; iTx_Data = '0;
    repeat (3) @(negedge iClk);
    vectors++; if (oMISO !== 1'b0) begin miscompares++; $display("FAIL reset_miso: got %b want 0", oMISO); end
    vectors++; if (oMISO_OE !== 1'b0) begin miscompares++; $display("FAIL reset_oe: got %b want 0", oMISO_OE); end
    vectors++; if (oRx_Data !== '0) begin miscompares++; $display("FAIL reset_rxdata: got %h want 000", oRx_Data); end
    vectors++; if (oRx_Valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", oRx_Valid); end
    vectors++; if (oFrame_Err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", oFrame_Err); end
    vectors++; if (oBusy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", oBusy); end
    iRst = 1'b0;
    modelRx = '0;
    repeat (6) @(negedge iClk);
    vectors++; if (oBusy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy: got %b want 0", oBusy); end
  endtask

  task automatic test_basic();
    logic [15:0] miso;
    logic act;
    logic [W-1:0] expTx;
    int v0, e0;
    v0 = validSeen; e0 = errSeen;
    expTx = expTxWord(10'h2A5);
    spiXfer({10'h1C3, 6'b0}, 10, 10'h2A5, miso, act);
    modelRx = 10'h1C3;
    vectors++; if (validSeen - v0 != 1) begin miscompares++; $display("FAIL basic_valid: got %0d pulses want 1", validSeen - v0); end
    vectors++; if (errSeen != e0) begin miscompares++; $display("FAIL basic_err: got %0d pulses want 0", errSeen - e0); end
    vectors++; if (oRx_Data !== 10'h1C3) begin miscompares++; $display("FAIL basic_rx: got %h want 1c3", oRx_Data); end
    vectors++; if (miso !== expMiso(expTx, 10)) begin miscompares++; $display("FAIL basic_miso: got %h want %h", miso, expMiso(expTx, 10)); end
    vectors++; if (act !== 1'b1) begin miscompares++; $display("FAIL basic_active: got %b want 1", act); end
    vectors++; if (oBusy !== 1'b0 || oMISO_OE !== 1'b0) begin miscompares++; $display("FAIL basic_idle_after: got busy %b oe %b want 0 0", oBusy, oMISO_OE); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] miso;
    logic act;
    logic [W-1:0] words [2];
    logic [W-1:0] expTx, tx;
    int v0, e0;
    words[0] = 10'h3FF; words[1] = 10'h000;
    e0 = errSeen;
    for (int unsigned k = 0; k < 2; k++) begin
      v0 = validSeen;
      tx = W'($urandom);
      expTx = expTxWord(tx);
      spiXfer({words[k], 6'b0}, 10, tx, miso, act);
      modelRx = words[k];
      vectors++; if (validSeen - v0 != 1) begin miscompares++; $display("FAIL b2b_valid%0d: got %0d pulses want 1", k, validSeen - v0); end
      vectors++; if (oRx_Data !== words[k]) begin miscompares++; $display("FAIL b2b_rx%0d: got %h want %h", k, oRx_Data, words[k]); end
      vectors++; if (miso !== expMiso(expTx, 10)) begin miscompares++; $display("FAIL b2b_miso%0d: got %h want %h", k, miso, expMiso(expTx, 10)); end
    end
    vectors++; if (errSeen != e0) begin miscompares++; $display("FAIL b2b_err: got %0d pulses want 0", errSeen - e0); end
  endtask

  task automatic test_short_frame();
    logic [15:0] miso;
    logic act;
    logic [W-1:0] expTx, tx;
    int v0, e0;
    v0 = validSeen; e0 = errSeen;
    tx = W'($urandom);
    expTx = expTxWord(tx);
    spiXfer(16'($urandom), 6, tx, miso, act);
    vectors++; if (errSeen - e0 != 1) begin miscompares++; $display("FAIL short_err: got %0d pulses want 1", errSeen - e0); end
    vectors++; if (validSeen != v0) begin miscompares++; $display("FAIL short_valid: got %0d pulses want 0", validSeen - v0); end
    vectors++; if (oRx_Data !== modelRx) begin miscompares++; $display("FAIL short_rx_held: got %h want %h", oRx_Data, modelRx); end
    vectors++; if (miso !== expMiso(expTx, 6)) begin miscompares++; $display("FAIL short_miso: got %h want %h", miso, expMiso(expTx, 6)); end
    v0 = validSeen; e0 = errSeen;
    tx = W'($urandom);
    expTx = expTxWord(tx);
    spiXfer({10'h155, 6'b0}, 10, tx, miso, act);
    modelRx = 10'h155;
    vectors++; if (validSeen - v0 != 1 || errSeen != e0) begin miscompares++; $display("FAIL short_next_pulses: got valid %0d err %0d want 1 0", validSeen - v0, errSeen - e0); end
    vectors++; if (oRx_Data !== 10'h155) begin miscompares++; $display("FAIL short_next_rx: got %h want 155", oRx_Data); end
    vectors++; if (miso !== expMiso(expTx, 10)) begin miscompares++; $display("FAIL short_next_miso: got %h want %h", miso, expMiso(expTx, 10)); end
  endtask

  task automatic test_overrun();
    logic [15:0] miso;
    logic act;
    logic [W-1:0] expTx, tx;
    int v0, e0;
    v0 = validSeen; e0 = errSeen;
    tx = W'($urandom);
    expTx = expTxWord(tx);
    spiXfer({10'h0F0, 2'b11, 4'b0}, 12, tx, miso, act);
    modelRx = 10'h0F0;
    vectors++; if (validSeen - v0 != 1 || errSeen != e0) begin miscompares++; $display("FAIL over_pulses: got valid %0d err %0d want 1 0", validSeen - v0, errSeen - e0); end
    vectors++; if (oRx_Data !== 10'h0F0) begin miscompares++; $display("FAIL over_rx: got %h want 0f0", oRx_Data); end
    vectors++; if (miso !== expMiso(expTx, 12)) begin miscompares++; $display("FAIL over_miso: got %h want %h", miso, expMiso(expTx, 12)); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] miso;
    logic act;
    logic [W-1:0] expTx, tx;
    int v0, e0;
    iTx_Data = W'($urandom);
    halfBit();
    iSSn = 1'b0;
    halfBit();
    for (int unsigned i = 0; i < 5; i++) begin
      iMOSI = 1'($urandom); halfBit(); iSCLK = 1'b1; halfBit(); iSCLK = 1'b0;
    end
    iRst = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    modelRx = '0;
    vectors++; if ({oMISO, oMISO_OE, oRx_Valid, oFrame_Err, oBusy} !== 5'b0) begin miscompares++; $display("FAIL rstmid_ctrl: got miso,oe,valid,err,busy %b want 00000", {oMISO, oMISO_OE, oRx_Valid, oFrame_Err, oBusy}); end
    vectors++; if (oRx_Data !== '0) begin miscompares++; $display("FAIL rstmid_rx: got %h want 000", oRx_Data); end
    v0 = validSeen; e0 = errSeen;
    for (int unsigned i = 0; i < 5; i++) begin
      iMOSI = 1'($urandom); halfBit(); iSCLK = 1'b1; halfBit(); iSCLK = 1'b0;
    end
    halfBit();
    iSSn = 1'b1;
    repeat (8) halfBit();
    vectors++; if (validSeen != v0 || errSeen != e0) begin miscompares++; $display("FAIL rstmid_ignored: got valid %0d err %0d want 0 0", validSeen - v0, errSeen - e0); end
    vectors++; if (oRx_Data !== '0) begin miscompares++; $display("FAIL rstmid_rx_after: got %h want 000", oRx_Data); end
    tx = W'($urandom);
    expTx = expTxWord(tx);
    spiXfer({10'h2AA, 6'b0}, 10, tx, miso, act);
    modelRx = 10'h2AA;
    vectors++; if (validSeen - v0 != 1 || errSeen != e0) begin miscompares++; $display("FAIL rstmid_next_pulses: got valid %0d err %0d want 1 0", validSeen - v0, errSeen - e0); end
    vectors++; if (oRx_Data !== 10'h2AA) begin miscompares++; $display("FAIL rstmid_next_rx: got %h want 2aa", oRx_Data); end
    vectors++; if (miso !== expMiso(expTx, 10)) begin miscompares++; $display("FAIL rstmid_next_miso: got %h want %h", miso, expMiso(expTx, 10)); end
  endtask

  task automatic test_random();
    logic [15:0] miso, mosi;
    logic act;
    logic [W-1:0] expTx, tx;
    int unsigned n;
    int v0, e0, expV, expE;
    for (int unsigned k = 0; k < 24; k++) begin
      n = $urandom_range(0, 14);
      mosi = 16'($urandom);
      tx = W'($urandom);
      expTx = expTxWord(tx);
      v0 = validSeen; e0 = errSeen;
      spiXfer(mosi, n, tx, miso, act);
      expV = (n >= W) ? 1 : 0;
      expE = (n >= W) ? 0 : 1;
      if (n >= W) modelRx = mosi[15:6];
      vectors++; if (validSeen - v0 != expV || errSeen - e0 != expE) begin miscompares++; $display("FAIL rand%0d_pulses n=%0d: got valid %0d err %0d want %0d %0d", k, n, validSeen - v0, errSeen - e0, expV, expE); end
      vectors++; if (oRx_Data !== modelRx) begin miscompares++; $display("FAIL rand%0d_rx n=%0d: got %h want %h", k, n, oRx_Data, modelRx); end
      vectors++; if (miso !== expMiso(expTx, n)) begin miscompares++; $display("FAIL rand%0d_miso n=%0d: got %h want %h", k, n, miso, expMiso(expTx, n)); end
      if (n > 0) begin
        vectors++; if (act !== 1'b1) begin miscompares++; $display("FAIL rand%0d_active: got %b want 1", k, act); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_short_frame();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
